// File: rtl/tm1638_responder_pkg.sv
// Shared types and command encodings for the TM1638 device-side responder.
package tm1638_responder_pkg;

  typedef logic [7:0][7:0] segments_t;
  typedef logic [7:0]      leds_t;

  typedef enum logic [2:0] {
    R_IDLE,
    R_CMD,
    R_WRITE,
    R_READ,
    R_IGNORE
  } resp_state_t;

  localparam logic [1:0] CMD_DATA = 2'b01;
  localparam logic [1:0] CMD_CTRL = 2'b10;
  localparam logic [1:0] CMD_ADDR = 2'b11;

endpackage

// File: rtl/tm1638_responder_pin_sync.sv
// Multi-flop synchronizer for one host pin, with registered rise/fall pulses aligned to level.
module tm1638_responder_pin_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync  <= {SYNC_STAGES{RST_VAL}};
      level <= RST_VAL;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync  <= {sync[SYNC_STAGES-2:0], pin};
      level <= sync[SYNC_STAGES-1];
      rise  <= sync[SYNC_STAGES-1] & ~level;
      fall  <= ~sync[SYNC_STAGES-1] & level;
    end
  end

endmodule

// File: rtl/tm1638_responder.sv
// TM1638 device-side responder: decodes host commands, holds display state, returns key bytes.
//   state    | meaning
//   R_IDLE   | no frame open, waiting for STB to fall
//   R_CMD    | shifting in the command byte
//   R_WRITE  | shifting display-RAM data bytes
//   R_READ   | driving key-scan bits on sclk falling edges
//   R_IGNORE | frame content irrelevant, waiting for STB to rise
module tm1638_responder
  import tm1638_responder_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stb_i,
  input  logic        sclk_i,
  input  logic        dio_i,
  output logic        dio_o,
  output logic        dio_oe,
  input  logic [31:0] keys_i,
  output segments_t   segments_o,
  output leds_t       leds_o,
  output logic        display_on,
  output logic [2:0]  brightness,
  output logic        ram_wr
);

  logic stb_lvl, stb_rise, stb_fall;
  logic sclk_lvl, sclk_rise, sclk_fall;
  logic dio_lvl, dio_rise, dio_fall;

  tm1638_responder_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_stb (
    .clk(clk), .rst(rst), .pin(stb_i), .level(stb_lvl), .rise(stb_rise), .fall(stb_fall));
  tm1638_responder_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sclk (
    .clk(clk), .rst(rst), .pin(sclk_i), .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall));
  tm1638_responder_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_dio (
    .clk(clk), .rst(rst), .pin(dio_i), .level(dio_lvl), .rise(dio_rise), .fall(dio_fall));

  logic unused_ok;
  assign unused_ok = &{1'b0, stb_lvl, sclk_lvl, dio_rise, dio_fall};

  resp_state_t state;
  logic [2:0]  bit_cnt;
  logic [4:0]  rd_cnt;
  logic [6:0]  rx_sr;
  logic [31:0] tx_sr;
  logic [3:0]  addr;
  logic        mode_read;
  logic        addr_fixed;

  // Seven bits are already held; the eighth arrives with the current rising edge.
  logic [7:0] rx_byte;
  logic       byte_done;
  assign rx_byte   = {dio_lvl, rx_sr};
  assign byte_done = sclk_rise && (bit_cnt == 3'd7);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= R_IDLE;
      bit_cnt    <= '0;
      rd_cnt     <= '0;
      rx_sr      <= '0;
      tx_sr      <= '0;
      addr       <= '0;
      mode_read  <= 1'b0;
      addr_fixed <= 1'b0;
      segments_o <= '0;
      leds_o     <= '0;
      display_on <= 1'b0;
      brightness <= '0;
      dio_o      <= 1'b1;
      dio_oe     <= 1'b0;
      ram_wr     <= 1'b0;
    end else begin
      ram_wr <= 1'b0;
      if (stb_rise) begin
        state   <= R_IDLE;
        bit_cnt <= '0;
        rd_cnt  <= '0;
        addr    <= '0;
        dio_oe  <= 1'b0;
        dio_o   <= 1'b1;
      end else begin
        case (state)
          R_IDLE: begin
            if (stb_fall) begin
              state   <= R_CMD;
              bit_cnt <= '0;
            end
          end
          R_CMD: begin
            if (sclk_rise) begin
              rx_sr   <= rx_byte[7:1];
              bit_cnt <= bit_cnt + 3'd1;
            end
            if (byte_done) begin
              state <= R_IGNORE;
              case (rx_byte[7:6])
                CMD_DATA: begin
                  mode_read  <= rx_byte[1];
                  addr_fixed <= rx_byte[2];
                  if (rx_byte[1]) begin
                    state  <= R_READ;
                    dio_oe <= 1'b1;
                    tx_sr  <= keys_i;
                    rd_cnt <= '0;
                  end
                end
                CMD_ADDR: begin
                  addr <= rx_byte[3:0];
                  if (!mode_read) state <= R_WRITE;
                end
                CMD_CTRL: begin
                  display_on <= rx_byte[3];
                  brightness <= rx_byte[2:0];
                end
                default: ;
              endcase
            end
          end
          R_WRITE: begin
            if (sclk_rise) begin
              rx_sr   <= rx_byte[7:1];
              bit_cnt <= bit_cnt + 3'd1;
            end
            if (byte_done) begin
              if (addr[0]) leds_o[addr[3:1]] <= rx_byte[0];
              else         segments_o[addr[3:1]] <= rx_byte;
              ram_wr <= 1'b1;
              if (!addr_fixed) addr <= addr + 4'd1;
            end
          end
          R_READ: begin
            // Shift register refills with ones so any extra host clocks read back idle-high.
            if (sclk_fall) begin
              dio_o <= tx_sr[0];
              tx_sr <= {1'b1, tx_sr[31:1]};
            end else if (sclk_rise) begin
              rd_cnt <= rd_cnt + 5'd1;
              if (rd_cnt == 5'd31) dio_o <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
